// File: rtl/unidade_controle_jogo.sv
// unidade_controle_jogo: memory-game control FSM driving the counter/ROM/key-register datapath
module unidade_controle_jogo #(
  parameter int TIMEOUT = 3000,
  parameter int TW = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);
  localparam logic [3:0] INICIAL     = 4'h0;
  localparam logic [3:0] PREPARACAO  = 4'h1;
  localparam logic [3:0] ESPERA      = 4'h2;
  localparam logic [3:0] REGISTRA    = 4'h4;
  localparam logic [3:0] COMPARACAO  = 4'h5;
  localparam logic [3:0] PROXIMO     = 4'h6;
  localparam logic [3:0] FIM_ACERTOU = 4'hA;
  localparam logic [3:0] FIM_ERROU   = 4'hE;
  localparam logic [3:0] FIM_TIMEOUT = 4'hC;
  logic [3:0] estado, prox;
  logic jogada_d, pulso, expirou;
  logic [TW-1:0] conta;
  assign pulso = jogada & ~jogada_d;
  assign expirou = (TIMEOUT != 0) && (conta == TW'(TIMEOUT - 1));
  always_comb begin
    prox = INICIAL;
    case (estado)
      INICIAL:     prox = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO:  prox = ESPERA;
      ESPERA:      prox = pulso ? REGISTRA : expirou ? FIM_TIMEOUT : ESPERA;
      REGISTRA:    prox = COMPARACAO;
      COMPARACAO:  prox = !igual ? FIM_ERROU : fimC ? FIM_ACERTOU : PROXIMO;
      PROXIMO:     prox = ESPERA;
      FIM_ACERTOU, FIM_ERROU, FIM_TIMEOUT: prox = iniciar ? PREPARACAO : estado;
      default:     prox = INICIAL;
    endcase
  end
  // the timeout counter only runs in espera and saturates instead of wrapping
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado   <= INICIAL;
      jogada_d <= 1'b0;
      conta    <= '0;
    end else begin
      estado   <= prox;
      jogada_d <= jogada;
      conta    <= (estado == ESPERA) ? (&conta ? conta : conta + TW'(1)) : '0;
    end
  end
  assign zeraC     = (estado == INICIAL) || (estado == PREPARACAO);
  assign zeraR     = zeraC;
  assign registraR = estado == REGISTRA;
  assign contaC    = estado == PROXIMO;
  assign acertou   = estado == FIM_ACERTOU;
  assign errou     = estado == FIM_ERROU;
  assign timeout   = estado == FIM_TIMEOUT;
  assign pronto    = acertou | errou | timeout;
  assign db_estado = estado;
endmodule

// File: tb/tb_unidade_controle_jogo.sv
// tb_unidade_controle_jogo: scoreboarded game-level bench for the control FSM
module tb_unidade_controle_jogo;
  localparam int TO = 5;
  localparam logic [3:0] S_INI = 4'h0, S_PREP = 4'h1, S_ESP = 4'h2;
  localparam logic [3:0] S_ACE = 4'hA, S_ERR = 4'hE, S_TMO = 4'hC;
  logic clock = 0, reset = 0, iniciar = 0, jogada = 0, igual = 0, fimC = 0;
  logic zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;
  typedef struct {
    logic [3:0] code;
    int regs;
    int contas;
  } exp_t;
  exp_t sb[$];
  exp_t e_mon;
  int plan_d[16];
  bit plan_ig[16];
  int tests = 0, fails = 0;
  int regs_seen = 0, contas_seen = 0;
  logic pronto_q = 0;
  unidade_controle_jogo #(.TIMEOUT(TO), .TW(4)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada), .igual(igual), .fimC(fimC),
    .zeraC(zeraC), .contaC(contaC), .zeraR(zeraR), .registraR(registraR), .pronto(pronto),
    .acertou(acertou), .errou(errou), .timeout(timeout), .db_estado(db_estado)
  );
  always #5 clock = ~clock;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic push_exp(input logic [3:0] code, input int r, input int c);
    exp_t e;
    e.code = code;
    e.regs = r;
    e.contas = c;
    sb.push_back(e);
  endtask
  // game-level outcome: each play either beats the timeout window or ends the game
  function automatic exp_t model();
    exp_t e;
    e.code = S_INI;
    e.regs = 0;
    e.contas = 0;
    for (int k = 0; k < 16; k++) begin
      if (plan_d[k] >= TO) begin e.code = S_TMO; break; end
      e.regs++;
      if (!plan_ig[k]) begin e.code = S_ERR; break; end
      if (k == 15) begin e.code = S_ACE; break; end
      e.contas++;
    end
    return e;
  endfunction
  task automatic wait_state(input logic [3:0] s, output bit ok);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (db_estado == s) begin ok = 1; return; end
    end
    ok = 0;
    tests++;
    fails++;
    $display("FAIL wait_state: got %0d expected %0d", db_estado, s);
  endtask
  task automatic wait_pronto();
    for (int i = 0; i < 60; i++) begin
      if (pronto) return;
      @(negedge clock);
    end
    tests++;
    fails++;
    $display("FAIL wait_pronto: got %0d expected 1", pronto);
  endtask
  task automatic run_game();
    bit ok;
    sb.push_back(model());
    @(negedge clock) iniciar = 1;
    @(negedge clock) iniciar = 0;
    for (int k = 0; k < 16; k++) begin
      wait_state(S_ESP, ok);
      if (!ok) return;
      if (plan_d[k] >= TO) break;
      repeat (plan_d[k]) @(negedge clock);
      igual = plan_ig[k];
      fimC = (k == 15);
      jogada = 1;
      @(negedge clock) jogada = 0;
      if (!plan_ig[k]) break;
    end
    wait_pronto();
  endtask
  always @(negedge clock) begin
    if (db_estado == S_INI || db_estado == S_PREP) begin
      regs_seen = 0;
      contas_seen = 0;
    end
    if (registraR) regs_seen++;
    if (contaC) contas_seen++;
    if (pronto && !pronto_q) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_underflow: got game end in state %0d expected none", db_estado);
      end else begin
        e_mon = sb.pop_front();
        check("final_state", db_estado, e_mon.code);
        check("acertou", acertou, e_mon.code == S_ACE);
        check("errou", errou, e_mon.code == S_ERR);
        check("timeout", timeout, e_mon.code == S_TMO);
        check("registraR_pulses", regs_seen, e_mon.regs);
        check("contaC_pulses", contas_seen, e_mon.contas);
      end
    end
    pronto_q = pronto;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clock);
    check("rst_estado", db_estado, S_INI);
    check("rst_zeraC", zeraC, 1);
    check("rst_zeraR", zeraR, 1);
    check("rst_pronto", pronto, 0);
    reset = 1;
    @(negedge clock) iniciar = 1;
    @(negedge clock) iniciar = 0;
    check("start_prep", db_estado, S_PREP);
    check("prep_zeraC", zeraC, 1);
    @(negedge clock) check("start_espera", db_estado, S_ESP);
    @(negedge clock);
    #2 reset = 0;
    #1 check("async_rst_estado", db_estado, S_INI);
    check("async_rst_zeraC", zeraC, 1);
    check("async_rst_zeraR", zeraR, 1);
    check("async_rst_pronto", pronto, 0);
    @(negedge clock) reset = 1;
    push_exp(S_TMO, 0, 0);
    @(negedge clock) iniciar = 1;
    @(negedge clock) iniciar = 0;
    repeat (5) @(negedge clock);
    check("tmo_last_espera", db_estado, S_ESP);
    @(negedge clock) check("tmo_state", db_estado, S_TMO);
    check("tmo_flag", timeout, 1);
    for (int k = 0; k < 16; k++) begin plan_d[k] = 3; plan_ig[k] = 1; end
    run_game();
    plan_ig[2] = 0;
    run_game();
    @(negedge clock) jogada = 1;
    @(negedge clock) jogada = 0;
    check("errou_hold", db_estado, S_ERR);
    check("errou_hold_flag", errou, 1);
    push_exp(S_TMO, 0, 0);
    @(negedge clock) iniciar = 1;
    @(negedge clock) iniciar = 0;
    check("restart_prep", db_estado, S_PREP);
    check("restart_pronto", pronto, 0);
    check("restart_errou", errou, 0);
    check("restart_zeraC", zeraC, 1);
    check("restart_zeraR", zeraR, 1);
    wait_pronto();
    push_exp(S_ERR, 1, 0);
    @(negedge clock) begin iniciar = 1; jogada = 1; end
    @(negedge clock) iniciar = 0;
    repeat (3) @(negedge clock);
    check("held_key_espera", db_estado, S_ESP);
    check("held_key_noreg", registraR, 0);
    jogada = 0;
    @(negedge clock) begin jogada = 1; igual = 0; fimC = 0; end
    @(negedge clock) check("held_key_reg", registraR, 1);
    jogada = 0;
    wait_pronto();
    plan_d[0] = 4;
    plan_ig[0] = 0;
    run_game();
    repeat (40) begin
      for (int k = 0; k < 16; k++) begin
        plan_d[k] = ($urandom_range(0, 9) == 0) ? TO + int'($urandom_range(0, 1)) : int'($urandom_range(0, TO - 1));
        plan_ig[k] = $urandom_range(0, 19) != 0;
      end
      run_game();
    end
    repeat (3) @(negedge clock);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/unidade_controle_jogo.md
Name: unidade_controle_jogo

Overview:
- Control-unit FSM for the memory-sequence game.
- Sits directly upstream of the datapath (counter + sync ROM 16x4 + 4-bit key register + comparator) and drives its zeraC/contaC/zeraR/registraR controls.
- Consumes the datapath's chavesIgualMemoria and fimC.
- Detects key presses with an internal edge detector, sequences register/compare/advance for up to 16 plays, and ends in hit, miss or timeout.

Parameters:
- TIMEOUT, 3000, cycles allowed in espera without a play before timeout; 0 disables timeout.
- TW, 12, width of the internal timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- iniciar  in  1  start/restart request, level-sampled
- jogada  in  1  OR of the four key inputs, raw level
- igual  in  1  chavesIgualMemoria from the datapath
- fimC  in  1  RCO of the address counter (address == 15)
- zeraC  out  1  synchronous clear of the address counter
- contaC  out  1  address counter enable
- zeraR  out  1  clear of the key register
- registraR  out  1  key register load enable
- pronto  out  1  game finished
- acertou  out  1  all 16 plays correct
- errou  out  1  a play mismatched
- timeout  out  1  no play within TIMEOUT cycles
- db_estado  out  4  current state code

Behaviour:
- Reset (reset=0, asynchronous): state=inicial, jogada_d=0, timeout counter=0.
  - Outputs take inicial values immediately: zeraC=1, zeraR=1, all others 0, db_estado=0.
- Edge detector: jogada_d <= jogada every cycle in every state; jogada_pulso = jogada & ~jogada_d.
  - A key already held when espera is entered produces no pulse.
  - Pulses outside espera are discarded.
- All control outputs are Moore, decoded from state only.
- States (db_estado code), outputs, transitions:
  - inicial (0): zeraC=1, zeraR=1. iniciar=1 -> preparacao.
  - preparacao (1): zeraC=1, zeraR=1. Next cycle -> espera. Address becomes 0; ROM output is valid one edge later, during espera.
  - espera (2): no controls asserted.
    - jogada_pulso -> registra.
    - Else if TIMEOUT!=0 and count==TIMEOUT-1 -> fim_timeout.
    - Else stay, count++.
    - Pulse and timeout in the same cycle: pulse wins.
  - registra (4): registraR=1 for exactly 1 cycle -> comparacao.
  - comparacao (5): register and ROM outputs are stable.
    - igual=0 -> fim_errou.
    - igual=1 and fimC=1 -> fim_acertou.
    - Otherwise -> proximo.
  - proximo (6): contaC=1 for exactly 1 cycle -> espera. The ROM refreshes during the first espera cycle; the edge detector guarantees >=1 espera cycle before registra.
  - fim_acertou (A): pronto=1, acertou=1.
  - fim_errou (E): pronto=1, errou=1.
  - fim_timeout (C): pronto=1, timeout=1.
  - All fim states: hold while iniciar=0; iniciar=1 -> preparacao (restart without passing through inicial).
- Timeout counter:
  - Cleared in every state other than espera, so each espera entry starts at 0.
  - Saturates; never wraps.
- iniciar is ignored in every state except inicial and the fim states.
- Exactly one of acertou/errou/timeout is high, and only when pronto=1.
- Unused state encodings -> inicial on the next edge.
- Reset asserted mid-game: immediate return to inicial; the game is abandoned.

Test Plan:
- Reset low while in espera -> db_estado=0, zeraC=1, zeraR=1, pronto=0 in the same cycle, before any clock edge. Release reset, iniciar=1 for 1 cycle -> db_estado 0 -> 1 -> 2, with zeraC=1 during state 1.
- Full win: 16 plays, each a jogada rise after >=3 espera cycles, igual=1; fimC=1 only on the 16th comparacao.
  - Exactly 16 registraR pulses and 15 contaC pulses.
  - Ends in db_estado=A, pronto=1, acertou=1.
- Miss on 3rd play: igual=0 in the 3rd comparacao -> db_estado=E, errou=1, acertou=0.
  - contaC pulses = 2.
  - A further jogada leaves the state unchanged.
- TIMEOUT=5: enter espera with no jogada -> after exactly 5 cycles in espera, db_estado=C, timeout=1.
  - Repeat with jogada rising on the 5th espera cycle -> registra wins; no timeout.
- Held key: jogada=1 throughout preparacao and into espera -> stays in espera, no registraR. Drop then raise jogada -> registraR pulses one cycle after the rise.
- Restart from fim_errou: iniciar=1 -> preparacao (db_estado=1, zeraC=1, zeraR=1) -> espera; pronto/errou drop in the preparacao cycle.
